// File: rtl/matrix_pkg.sv
// matrix_pkg: shared matrix type codes, state encoding and
// the type-code -> (rows, cols) mapping used by read and write paths.
package matrix_pkg;

  localparam int MAX_DIM = 5;

  localparam logic [7:0] MT_2X2 = 8'd1;
  localparam logic [7:0] MT_3X3 = 8'd2;
  localparam logic [7:0] MT_4X4 = 8'd3;
  localparam logic [7:0] MT_5X5 = 8'd4;
  localparam logic [7:0] MT_V2  = 8'd5;
  localparam logic [7:0] MT_V3  = 8'd6;
  localparam logic [7:0] MT_V4  = 8'd7;
  localparam logic [7:0] MT_V5  = 8'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_SEND,
    ST_DONE,
    ST_ERR
  } state_t;

  typedef struct packed {
    logic [2:0] rows;
    logic [2:0] cols;
    logic       valid;
  } dims_t;

  // Squares are (type+1)x(type+1); vectors are a single row
  // of (type-3) elements. Anything else is invalid.
  function automatic dims_t mat_dims(input logic [7:0] t);
    dims_t d;
    d = '0;
    if (t >= MT_2X2 && t <= MT_5X5) begin
      d.rows  = 3'(t + 8'd1);
      d.cols  = 3'(t + 8'd1);
      d.valid = 1'b1;
    end else if (t >= MT_V2 && t <= MT_V5) begin
      d.rows  = 3'd1;
      d.cols  = 3'(t - 8'd3);
      d.valid = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/matrix_dim_decode.sv
// matrix_dim_decode: combinational type-code decoder.
// in: mat_type[7:0]; out: rows[2:0], cols[2:0], valid.
module matrix_dim_decode
  import matrix_pkg::*;
(
  input  logic [7:0] mat_type,
  output logic [2:0] rows,
  output logic [2:0] cols,
  output logic       valid
);

  dims_t d;

  assign d     = mat_dims(mat_type);
  assign rows  = d.rows;
  assign cols  = d.cols;
  assign valid = d.valid;

endmodule

// File: rtl/matrix_read_data.sv
// matrix_read_data: walks a stored matrix row-major, fetching
// each element and streaming it to the TX path over valid/ready.
// Ports: i_clk, reset (async high), i_start, mat_type[7:0],
//   o_busy, o_rd_en, o_rd_addr, i_rd_data, o_tx_data,
//   o_tx_valid, i_tx_ready, o_done, o_err.
module matrix_read_data #(
  parameter int DATA_W  = 8,
  parameter int MAX_DIM = matrix_pkg::MAX_DIM,
  parameter int ADDR_W  = 5
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [7:0]        mat_type,
  output logic              o_busy,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_done,
  output logic              o_err
);

  import matrix_pkg::*;

  state_t            state_q;
  state_t            state_d;
  logic [7:0]        type_q;
  logic [2:0]        row_q;
  logic [2:0]        col_q;
  logic [DATA_W-1:0] data_q;

  logic [7:0]        dec_type;
  logic [2:0]        rows;
  logic [2:0]        cols;
  logic              dim_ok;

  logic              last_col;
  logic              last_row;
  logic              go;
  logic              cap;
  logic              hs;
  logic [ADDR_W-1:0] addr;

  // In IDLE the live code is checked for validity; once running,
  // only the latched code drives the dimensions.
  assign dec_type = (state_q == ST_IDLE) ? mat_type : type_q;

  matrix_dim_decode u_dec (
    .mat_type (dec_type),
    .rows     (rows),
    .cols     (cols),
    .valid    (dim_ok)
  );

  assign last_col = (col_q == cols - 3'd1);
  assign last_row = (row_q == rows - 3'd1);
  assign go  = (state_q == ST_IDLE) && i_start && dim_ok;
  assign cap = (state_q == ST_LATCH);
  assign hs  = (state_q == ST_SEND) && i_tx_ready;

  assign addr = ADDR_W'(row_q) * ADDR_W'(MAX_DIM)
              + ADDR_W'(col_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = dim_ok ? ST_FETCH : ST_ERR;
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: state_d = ST_SEND;
      ST_SEND: begin
        if (i_tx_ready) begin
          state_d = (last_col && last_row) ? ST_DONE
                                           : ST_FETCH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      type_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      unique case (1'b1)
        go: begin
          type_q <= mat_type;
          row_q  <= '0;
          col_q  <= '0;
        end
        cap: data_q <= i_rd_data;
        hs: begin
          if (last_col) begin
            col_q <= '0;
            row_q <= row_q + 3'd1;
          end else begin
            col_q <= col_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy     = (state_q == ST_FETCH)
                   || (state_q == ST_LATCH)
                   || (state_q == ST_SEND);
  assign o_rd_en    = (state_q == ST_FETCH);
  assign o_rd_addr  = o_rd_en ? addr : '0;
  assign o_tx_data  = data_q;
  assign o_tx_valid = (state_q == ST_SEND);
  assign o_done     = (state_q == ST_DONE);
  assign o_err      = (state_q == ST_ERR);

endmodule

// File: tb/tb_matrix_read_data.sv
// tb_matrix_read_data: table-driven, hand-written and random
// read-outs of matrix_read_data against a row-major model.
module tb_matrix_read_data;

  localparam int AW = 5;

  logic          i_clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_start = 1'b0;
  logic [7:0]    mat_type = '0;
  logic          i_tx_ready = 1'b0;
  logic [7:0]    i_rd_data = 8'hEE;
  logic          o_busy;
  logic          o_rd_en;
  logic [AW-1:0] o_rd_addr;
  logic [7:0]    o_tx_data;
  logic          o_tx_valid;
  logic          o_done;
  logic          o_err;

  matrix_read_data #(
    .DATA_W  (8),
    .MAX_DIM (5),
    .ADDR_W  (AW)
  ) dut (
    .i_clk      (i_clk),
    .reset      (reset),
    .i_start    (i_start),
    .mat_type   (mat_type),
    .o_busy     (o_busy),
    .o_rd_en    (o_rd_en),
    .o_rd_addr  (o_rd_addr),
    .i_rd_data  (i_rd_data),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  logic [7:0] mem [32];
  int cyc = 0;
  int run_id = 0;
  int ready_mode = 0;

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  // 0: always ready, 1: ready one cycle in three, else random
  initial forever begin
    @(posedge i_clk);
    #2;
    case (ready_mode)
      0:       i_tx_ready = 1'b1;
      1:       i_tx_ready = (cyc % 3 == 0);
      default: i_tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic          pend = 1'b0;
  logic [AW-1:0] paddr = '0;

  // storage: data for a read strobe appears the following cycle
  initial forever begin
    @(posedge i_clk);
    #1;
    i_rd_data = pend ? mem[paddr] : 8'hEE;
  end

  logic [AW-1:0] q_addr [$];
  logic [7:0]    q_data [$];
  int   rd_cnt, done_cnt, err_cnt, hs_cnt, stab_bad;
  int   first_rd, done_cyc;
  int   last_id = 0;
  bit   busy_seen;
  logic pv = 1'b0;
  logic pr = 1'b0;
  logic [7:0] pd = '0;

  initial forever begin
    @(negedge i_clk);
    if (run_id != last_id) begin
      q_addr.delete();
      q_data.delete();
      rd_cnt = 0; done_cnt = 0; err_cnt = 0;
      hs_cnt = 0; stab_bad = 0;
      first_rd = -1; done_cyc = -1;
      busy_seen = 0;
      last_id = run_id;
    end
    pend = 1'b0;
    if (!reset) begin
      if (pv && !pr && (!o_tx_valid || o_tx_data != pd))
        stab_bad++;
      if (o_rd_en) begin
        pend = 1'b1;
        paddr = o_rd_addr;
        q_addr.push_back(o_rd_addr);
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (o_tx_valid && i_tx_ready) begin
        q_data.push_back(o_tx_data);
        hs_cnt++;
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (o_err) err_cnt++;
      if (o_busy) busy_seen = 1;
      pv = o_tx_valid;
      pr = i_tx_ready;
      pd = o_tx_data;
    end else begin
      pv = 1'b0;
    end
  end

  // Reference: row-major walk of the shape named by the type code.
  int exp_addr [$];
  bit exp_err;

  function automatic void build_ref(input logic [7:0] t);
    int r, c;
    exp_addr.delete();
    if (t >= 1 && t <= 4) begin
      r = int'(t) + 1; c = int'(t) + 1;
    end else if (t >= 5 && t <= 8) begin
      r = 1; c = int'(t) - 3;
    end else begin
      r = 0; c = 0;
    end
    exp_err = (r == 0);
    for (int i = 0; i < r; i++)
      for (int j = 0; j < c; j++)
        exp_addr.push_back(i * 5 + j);
  endfunction

  task automatic start_op(input logic [7:0] t, output int s);
    @(posedge i_clk);
    #2;
    i_start = 1'b1;
    mat_type = t;
    s = cyc;
    @(posedge i_clk);
    #2;
    i_start = 1'b0;
    mat_type = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_end(input string nm, input int budget);
    int k = 0;
    while (done_cnt + err_cnt == 0 && k < budget) begin
      @(posedge i_clk);
      k++;
    end
    check({nm, " finished"}, int'(done_cnt + err_cnt > 0), 1);
    repeat (5) @(posedge i_clk);
  endtask

  task automatic check_run(input string nm, input logic [7:0] t,
                           input int exp_n);
    int a, d;
    build_ref(t);
    check({nm, " rd_cnt"}, rd_cnt, exp_addr.size());
    check({nm, " hs_cnt"}, hs_cnt, exp_n);
    check({nm, " done"}, done_cnt, exp_err ? 0 : 1);
    check({nm, " err"}, err_cnt, exp_err ? 1 : 0);
    check({nm, " busy"}, int'(busy_seen), exp_err ? 0 : 1);
    check({nm, " stable"}, stab_bad, 0);
    foreach (exp_addr[i]) begin
      a = (i < q_addr.size()) ? int'(q_addr[i]) : -1;
      d = (i < q_data.size()) ? int'(q_data[i]) : -1;
      check($sformatf("%s addr[%0d]", nm, i), a, exp_addr[i]);
      check($sformatf("%s data[%0d]", nm, i), d,
            int'(mem[exp_addr[i]]));
    end
  endtask

  task automatic run(input string nm, input logic [7:0] t,
                     input int rmode, input int exp_n,
                     output int s);
    ready_mode = rmode;
    run_id++;
    start_op(t, s);
    wait_end(nm, 600);
    check_run(nm, t, exp_n);
  endtask

  typedef struct {
    logic [7:0] t;
    int         rmode;
    int         exp_n;
  } vec_t;

  vec_t vt [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, k;
    vt[0] = '{8'd1, 0, 4};
    vt[1] = '{8'd8, 0, 5};
    vt[2] = '{8'd4, 1, 25};
    vt[3] = '{8'd0, 0, 0};
    vt[4] = '{8'd9, 0, 0};
    vt[5] = '{8'd2, 2, 9};
    vt[6] = '{8'd5, 1, 2};
    vt[7] = '{8'd3, 0, 16};
    for (int i = 0; i < 32; i++) mem[i] = 8'(i + 16);

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("reset outputs",
          int'({o_busy, o_rd_en, o_tx_valid, o_done, o_err}), 0);
    check("reset addr", int'(o_rd_addr), 0);
    check("reset tx_data", int'(o_tx_data), 0);
    @(posedge i_clk);
    #2;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run($sformatf("vec%0d", i), vt[i].t, vt[i].rmode,
          vt[i].exp_n, s);
      if (i == 0) begin
        check("2x2 rd_en cycle", first_rd - s, 1);
        check("2x2 done cycle", done_cyc - s, 13);
      end
    end

    // second start during SEND must be ignored
    ready_mode = 1;
    run_id++;
    start_op(8'd2, s);
    k = 0;
    while (!o_tx_valid && k < 50) begin
      @(negedge i_clk);
      k++;
    end
    check("restart reached send", int'(o_tx_valid), 1);
    i_start = 1'b1;
    mat_type = 8'd1;
    @(posedge i_clk);
    #2;
    i_start = 1'b0;
    wait_end("restart", 600);
    check_run("restart", 8'd2, 9);

    // reset mid-stream after the 5th handshake
    ready_mode = 0;
    run_id++;
    start_op(8'd3, s);
    k = 0;
    while (hs_cnt < 5 && k < 200) begin
      @(posedge i_clk);
      k++;
    end
    check("reset hs reached", hs_cnt, 5);
    #3;
    reset = 1'b1;
    #1;
    check("midreset outputs",
          int'({o_busy, o_rd_en, o_tx_valid, o_done, o_err}), 0);
    check("midreset tx_data", int'(o_tx_data), 0);
    repeat (4) @(posedge i_clk);
    #2;
    reset = 1'b0;
    repeat (4) @(posedge i_clk);
    check("midreset no done", done_cnt, 0);
    check("midreset idle", int'(o_busy), 0);
    run("after reset", 8'd1, 0, 4, s);
    check("after reset rd_en cycle", first_rd - s, 1);
    check("after reset done cycle", done_cyc - s, 13);

    // random shapes, data and ready patterns
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 14; i++) begin
      logic [7:0] t;
      t = 8'($urandom_range(0, 10));
      build_ref(t);
      run($sformatf("rand%0d t%0d", i, t), t,
          $urandom_range(0, 2), exp_addr.size(), s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/matrix_read_data.md
Name: matrix_read_data

Overview:
- Read-side counterpart of the matrix write path. It takes a matrix type code and walks the stored matrix elements in row-major order.
- Drives the read select/address toward the storage MUX and fetches each 8-bit element.
- Streams elements byte-by-byte to the host transmitter over a valid/ready handshake, then pulses done.
- Sits between matrix storage and the UART TX path of the co-processor.

Parameters:
- DATA_W, 8, element width in bits
- MAX_DIM, 5, maximum row/column count; also the storage row pitch
- ADDR_W, 5, read address width; must satisfy 2^ADDR_W >= MAX_DIM*MAX_DIM

Ports:
- i_clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- i_start  in  1  single-cycle request to begin a read-out
- mat_type  in  8  type code: 1-4 = square 2x2..5x5, 5-8 = vector 2..5 elements (row 0)
- o_busy  out  1  high from accepted start until the done or error pulse
- o_rd_en  out  1  storage read strobe, one cycle per element
- o_rd_addr  out  ADDR_W  storage address = row*MAX_DIM + col
- i_rd_data  in  DATA_W  storage read data, valid exactly one cycle after o_rd_en
- o_tx_data  out  DATA_W  element byte to the transmitter
- o_tx_valid  out  1  o_tx_data valid
- i_tx_ready  in  1  transmitter accepts the byte this cycle
- o_done  out  1  one-cycle pulse after the last element handshake
- o_err  out  1  one-cycle pulse on an invalid mat_type

Behaviour:
- Clock and reset: one clock (i_clk); reset is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; row, col and stored type cleared.
- States: IDLE, FETCH, LATCH, SEND, DONE, ERR.
- IDLE:
  - i_start=1 with mat_type in 1..8: latch mat_type, row=0, col=0, go to FETCH.
  - i_start=1 with mat_type 0 or >8: go to ERR.
  - i_start=0: stay in IDLE.
- Dimensions:
  - Types 1-4: rows = cols = type+1.
  - Types 5-8: rows = 1, cols = type-3.
  - Dimensions are computed from the latched type only; a mat_type change mid-operation has no effect.
- FETCH (1 cycle): o_rd_en=1, o_rd_addr = row*MAX_DIM+col; go to LATCH.
- LATCH (1 cycle): capture i_rd_data into o_tx_data, set o_tx_valid=1, go to SEND.
- SEND:
  - Hold o_tx_valid and a stable o_tx_data until i_tx_ready=1.
  - On the handshake cycle, drop o_tx_valid at the next edge.
  - If col=cols-1 and row=rows-1: go to DONE.
  - Else if col=cols-1: col=0, row+1, go to FETCH.
  - Else: col+1, go to FETCH.
- DONE: o_done=1 for one cycle, o_busy=0, then go to IDLE.
- ERR: o_err=1 for one cycle, no o_rd_en issued, then go to IDLE.
- o_busy is 1 in FETCH, LATCH and SEND.
- Timing:
  - Start sampled at edge N gives o_rd_en high in cycle N+1 and o_tx_valid high from cycle N+2.
  - Element throughput is 3 cycles with i_tx_ready held high.
  - A 2x2 matrix with ready held high gives o_done in cycle N+13.
- i_start while o_busy=1 is ignored (no restart, no queueing).
- i_tx_ready while o_tx_valid=0 is ignored.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. The partial stream is abandoned and no o_done is issued.
- Address arithmetic is ADDR_W bits; the maximum address is 24 (5x5), so no wrap-around occurs.

Decomposition:
- Shared package (matrix_pkg):
  - Type code constants: MT_2X2..MT_5X5 = 1..4, MT_V2..MT_V5 = 5..8.
  - MAX_DIM.
  - FSM state encoding.
  - A function mapping type code to (rows, cols), also to be used by the write-side demux logic.
- Sub-module: matrix_dim_decode, combinational. Inputs: latched type. Outputs: rows, cols, valid.

Test Plan:
- Type 1, storage preloaded with addr value = addr+0x10, ready held high → o_rd_addr sequence 0,1,5,6; tx bytes 0x10,0x11,0x15,0x16; o_done one cycle; 4 handshakes total.
- Type 8 (vector of 5) → addresses 0,1,2,3,4; 5 bytes sent; o_done pulses; o_rd_en asserted exactly 5 times.
- Type 4 (5x5) with i_tx_ready toggling 1-of-3 cycles → 25 bytes in row-major order (last addr 24); o_tx_data stable while valid and not ready; no byte lost or duplicated.
- mat_type 0, then mat_type 9 → o_err pulses once for each; o_rd_en never asserted; o_busy stays 0.
- Type 2 started, second i_start with type 1 during SEND → ignored; all 9 elements of 3x3 sent; a single o_done.
- Type 3 started, reset asserted after the 5th handshake → all outputs 0 asynchronously; no o_done; a fresh start of type 1 afterward behaves as in the first scenario.
